// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: operand registers, button conditioning and writeback
// sequencing for the 4-bit add/subtract ALU lab datapath.
module alu_operand_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_inc_a,
    input  logic             btn_inc_b,
    input  logic             btn_exec,
    input  logic             op_sub,
    input  logic             dst_sel,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_co,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ctrl,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] WB     = 2'd2;

    logic [2:0]    btn;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    s3;
    logic [2:0]    pulse;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          dst_r;

    // Bit order: 0 = inc_a, 1 = inc_b, 2 = exec
    assign btn   = {btn_exec, btn_inc_b, btn_inc_a};
    assign pulse = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= 1'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            dst_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pulse[0])
                        alu_a <= alu_a + WIDTH'(1);
                    if (pulse[1])
                        alu_b <= alu_b + WIDTH'(1);
                    if (pulse[2]) begin
                        alu_ctrl <= op_sub;
                        dst_r    <= dst_sel;
                        cnt      <= CNT_INIT;
                        state    <= SETTLE;
                        busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0)
                        state <= WB;
                    else
                        cnt <= cnt - CW'(1);
                end
                WB: begin
                    if (dst_r)
                        alu_b <= alu_s;
                    else
                        alu_a <= alu_s;
                    flag_c <= alu_co;
                    flag_z <= (alu_s == '0);
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// tb_alu_operand_ctrl: directed vector table plus hand-timed sequences
// for alu_operand_ctrl, with a behavioural add/subtract ALU attached.
module tb_alu_operand_ctrl;

    localparam int W = 4;

    localparam logic [2:0] OP_RST  = 3'd0;
    localparam logic [2:0] OP_INCA = 3'd1;
    localparam logic [2:0] OP_INCB = 3'd2;
    localparam logic [2:0] OP_INCAB = 3'd3;
    localparam logic [2:0] OP_EXEC = 3'd4;
    localparam logic [2:0] OP_EXIA = 3'd5;

    typedef struct {
        logic [2:0]   op;
        logic         sub;
        logic         dst;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ectl;
        logic         ec;
        logic         ez;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_inc_a;
    logic         btn_inc_b;
    logic         btn_exec;
    logic         op_sub;
    logic         dst_sel;
    logic [W-1:0] alu_s;
    logic         alu_co;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_ctrl;
    logic         flag_c;
    logic         flag_z;
    logic         busy;
    logic [W:0]   sum;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    // Behavioural ALU: A + B, or A + ~B + 1 when subtracting
    always_comb begin
        sum = {1'b0, alu_a}
            + {1'b0, (alu_ctrl ? ~alu_b : alu_b)}
            + {{W{1'b0}}, alu_ctrl};
        alu_s  = sum[W-1:0];
        alu_co = sum[W];
    end

    alu_operand_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_inc_a (btn_inc_a),
        .btn_inc_b (btn_inc_b),
        .btn_exec  (btn_exec),
        .op_sub    (op_sub),
        .dst_sel   (dst_sel),
        .alu_s     (alu_s),
        .alu_co    (alu_co),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_rst();
        rst       = 1'b1;
        btn_inc_a = 1'b0;
        btn_inc_b = 1'b0;
        btn_exec  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic ia, input logic ib,
                         input logic ex, input logic sub,
                         input logic dst);
        btn_inc_a = ia;
        btn_inc_b = ib;
        btn_exec  = ex;
        op_sub    = sub;
        dst_sel   = dst;
        repeat (3) @(negedge clk);
        btn_inc_a = 1'b0;
        btn_inc_b = 1'b0;
        btn_exec  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic add_v(input logic [2:0] op, input logic sub,
                         input logic dst, input logic [W-1:0] ea,
                         input logic [W-1:0] eb, input logic ectl,
                         input logic ec, input logic ez);
        vec_t v;
        v.op = op; v.sub = sub; v.dst = dst;
        v.ea = ea; v.eb = eb; v.ectl = ectl;
        v.ec = ec; v.ez = ez;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn_inc_a = 1'b0; btn_inc_b = 1'b0;
        btn_exec = 1'b0; op_sub = 1'b0; dst_sel = 1'b0;

        add_v(OP_RST,  0, 0, 4'h0, 4'h0, 0, 0, 0);
        add_v(OP_INCA, 0, 0, 4'h1, 4'h0, 0, 0, 0);
        add_v(OP_INCA, 0, 0, 4'h2, 4'h0, 0, 0, 0);
        add_v(OP_INCA, 0, 0, 4'h3, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add_v(OP_INCB, 0, 0, 4'h3, W'(i), 0, 0, 0);
        add_v(OP_EXEC, 0, 0, 4'h8, 4'h5, 0, 0, 0);
        add_v(OP_RST,  0, 0, 4'h0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add_v(OP_INCAB, 0, 0, W'(i), W'(i), 0, 0, 0);
        add_v(OP_EXEC, 1, 1, 4'h5, 4'h0, 1, 1, 1);
        add_v(OP_RST,  0, 0, 4'h0, 4'h0, 0, 0, 0);
        add_v(OP_INCAB, 0, 0, 4'h1, 4'h1, 0, 0, 0);
        add_v(OP_INCAB, 0, 0, 4'h2, 4'h2, 0, 0, 0);
        add_v(OP_INCB, 0, 0, 4'h2, 4'h3, 0, 0, 0);
        add_v(OP_INCB, 0, 0, 4'h2, 4'h4, 0, 0, 0);
        add_v(OP_INCB, 0, 0, 4'h2, 4'h5, 0, 0, 0);
        add_v(OP_EXEC, 1, 0, 4'hD, 4'h5, 1, 0, 0);
        add_v(OP_RST,  0, 0, 4'h0, 4'h0, 0, 0, 0);
        add_v(OP_INCB, 0, 0, 4'h0, 4'h1, 0, 0, 0);
        add_v(OP_EXEC, 1, 0, 4'hF, 4'h1, 1, 0, 0);
        add_v(OP_EXEC, 0, 0, 4'h0, 4'h1, 0, 1, 1);
        add_v(OP_RST,  0, 0, 4'h0, 4'h0, 0, 0, 0);
        add_v(OP_INCB, 0, 0, 4'h0, 4'h1, 0, 0, 0);
        add_v(OP_EXEC, 1, 0, 4'hF, 4'h1, 1, 0, 0);
        add_v(OP_INCA, 0, 0, 4'h0, 4'h1, 1, 0, 0);
        add_v(OP_EXIA, 0, 1, 4'h1, 4'h2, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OP_RST:   do_rst();
                OP_INCA:  press(1, 0, 0, 0, 0);
                OP_INCB:  press(0, 1, 0, 0, 0);
                OP_INCAB: press(1, 1, 0, 0, 0);
                OP_EXEC:  press(0, 0, 1, vecs[i].sub, vecs[i].dst);
                OP_EXIA:  press(1, 0, 1, vecs[i].sub, vecs[i].dst);
                default:  do_rst();
            endcase
            chk($sformatf("v%0d.a", i), alu_a, vecs[i].ea);
            chk($sformatf("v%0d.b", i), alu_b, vecs[i].eb);
            chk($sformatf("v%0d.ctrl", i), alu_ctrl, vecs[i].ectl);
            chk($sformatf("v%0d.c", i), flag_c, vecs[i].ec);
            chk($sformatf("v%0d.z", i), flag_z, vecs[i].ez);
            chk($sformatf("v%0d.busy", i), busy, 0);
        end

        // Held inc_a: update lands two edges after first sample, once only
        do_rst();
        btn_inc_a = 1'b1;
        @(negedge clk);
        chk("hold.k", alu_a, 0);
        @(negedge clk);
        chk("hold.k1", alu_a, 0);
        @(negedge clk);
        chk("hold.k2", alu_a, 1);
        repeat (20) @(negedge clk);
        chk("hold.held", alu_a, 1);
        btn_inc_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold.rel", alu_a, 1);
        press(0, 1, 0, 0, 0);
        chk("hold.b", alu_b, 1);

        // Busy window and dropped presses: A=1, B=1, add into A
        op_sub = 1'b0; dst_sel = 1'b0;
        btn_exec = 1'b1;
        @(negedge clk);
        btn_exec = 1'b0;
        @(negedge clk);
        chk("busy.k1", busy, 0);
        btn_exec  = 1'b1;
        btn_inc_b = 1'b1;
        @(negedge clk);
        chk("busy.k2", busy, 1);
        @(negedge clk);
        chk("busy.k3", busy, 1);
        chk("busy.k3a", alu_a, 1);
        @(negedge clk);
        chk("busy.k4", busy, 0);
        chk("busy.k4a", alu_a, 2);
        btn_exec  = 1'b0;
        btn_inc_b = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop.b", alu_b, 1);
        chk("drop.a", alu_a, 2);
        chk("drop.busy", busy, 0);

        // Reset while in SETTLE abandons the add
        do_rst();
        repeat (3) press(1, 0, 0, 0, 0);
        repeat (5) press(0, 1, 0, 0, 0);
        chk("rs.a0", alu_a, 3);
        chk("rs.b0", alu_b, 5);
        btn_exec = 1'b1;
        repeat (3) @(negedge clk);
        chk("rs.busy", busy, 1);
        rst      = 1'b1;
        btn_exec = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rs.a", alu_a, 0);
        chk("rs.b", alu_b, 0);
        chk("rs.c", flag_c, 0);
        chk("rs.z", flag_z, 0);
        chk("rs.bz", busy, 0);
        repeat (5) @(negedge clk);
        chk("rs.late_a", alu_a, 0);
        chk("rs.late_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
